// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, default geometry and drain-length helper
// for the streaming FFT stage sequencer.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   localparam int DEF_CBW  = 3;
   localparam int DEF_NST  = 3;
   localparam int DEF_SLAT = 2;

   // Cycles needed for the last accepted sample to leave the final stage.
   function automatic int drain_len(input int nst, input int slat);
      return nst * slat;
   endfunction

endpackage

// File: rtl/fft_stage_cnt.sv
// fft_stage_cnt: one sequenced pipeline stage. Delays the incoming
// (valid, first) framing pair by SLAT cycles and keeps a modulo-N sample
// counter that lines up with the delayed pair. A synchronous flush clears
// the whole delay line and the counter.
module fft_stage_cnt
   import fft_pkg::*;
#(
   parameter int CBW  = DEF_CBW,
   parameter int SLAT = DEF_SLAT
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   input  logic           in_first,
   output logic           out_valid,
   output logic           out_first,
   output logic [CBW-1:0] cnt
);

   logic pre_valid;
   logic pre_first;

   generate
      if (SLAT > 1) begin : g_dly
         logic [SLAT-2:0] dly_valid;
         logic [SLAT-2:0] dly_first;

         // Carry the framing pair through the first SLAT-1 slots of the delay line.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dly_valid <= '0;
               dly_first <= '0;
            end else if (flush) begin
               dly_valid <= '0;
               dly_first <= '0;
            end else begin
               dly_valid[0] <= in_valid;
               dly_first[0] <= in_first;
               for (int i = 1; i < SLAT - 1; i++) begin
                  dly_valid[i] <= dly_valid[i-1];
                  dly_first[i] <= dly_first[i-1];
               end
            end
         end

         assign pre_valid = dly_valid[SLAT-2];
         assign pre_first = dly_first[SLAT-2];
      end else begin : g_nodly
         assign pre_valid = in_valid;
         assign pre_first = in_first;
      end
   endgenerate

   // Final slot: the active flag, its first tag and the counter update together,
   // so cnt always shows the index of the sample the stage currently holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         cnt       <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         cnt       <= '0;
      end else begin
         out_valid <= pre_valid;
         out_first <= pre_valid & pre_first;
         if (pre_valid) begin
            cnt <= pre_first ? '0 : cnt + CBW'(1);
         end
      end
   end

endmodule

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: sequencer for the streaming FFT pipeline. Tracks the framed
// input stream, hands each of NST chained stages its sample counter and
// active flag, produces framed output flags and drains the pipe after the
// final frame.
// Build option: define FFT_SEQ_ERR_EN to enable framing-error detection
// (sticky err, err_clr, pipeline flush). Without it, err is tied low and an
// input gap inside a frame simply starts the drain.
module fft_stage_seq
   import fft_pkg::*;
#(
   parameter int CBW  = DEF_CBW,
   parameter int NST  = DEF_NST,
   parameter int SLAT = DEF_SLAT
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_first,
   output logic [NST*CBW-1:0] stage_cnt,
   output logic [NST-1:0]     stage_act,
   output logic               out_valid,
   output logic               out_first,
   output logic               out_last,
   output logic               busy,
   output logic               err,
   input  logic               err_clr
);

   localparam int             D     = drain_len(NST, SLAT);
   localparam int             DW    = $clog2(D + 1);
   localparam logic [DW-1:0]  D_VAL = DW'(D);

   seq_state_t     state;
   seq_state_t     state_nxt;
   logic [CBW-1:0] mcnt;
   logic [DW-1:0]  dcnt;
   logic           mcnt_zero;
   logic           err_event;
   logic           acc_valid;
   logic           acc_first;

   logic [NST-1:0] act_vec;
   logic [NST-1:0] first_vec;
   logic [CBW-1:0] cnt_arr [NST];

   assign mcnt_zero = (mcnt == '0);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, including framing-error detection while running.
   always_comb begin
      state_nxt = state;
      err_event = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && in_first) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
`ifdef FFT_SEQ_ERR_EN
            if ((!in_valid && !mcnt_zero) || (in_valid && (in_first != mcnt_zero))) begin
               err_event = 1'b1;
               state_nxt = IDLE;
            end else if (!in_valid) begin
               state_nxt = DRAIN;
            end
`else
            if (!in_valid) begin
               state_nxt = DRAIN;
            end
`endif
         end
         DRAIN: begin
            if (in_valid && in_first) begin
               state_nxt = RUN;
            end else if (dcnt == DW'(1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: a sample enters stage 0 exactly when the FSM is in RUN
   // next cycle; it is tagged first on frame entry or at a frame boundary.
   always_comb begin
      acc_valid = (state_nxt == RUN);
      acc_first = acc_valid && ((state != RUN) || mcnt_zero);
      busy      = (state != IDLE);
   end

   // Master sample counter and drain down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= '0;
         dcnt <= '0;
      end else begin
         if (state_nxt == RUN) begin
            mcnt <= (state == RUN) ? mcnt + CBW'(1) : CBW'(1);
         end else begin
            mcnt <= '0;
         end
         if (state_nxt == DRAIN) begin
            dcnt <= (state == DRAIN) ? dcnt - DW'(1) : D_VAL;
         end else begin
            dcnt <= '0;
         end
      end
   end

`ifdef FFT_SEQ_ERR_EN
   // Sticky framing error; a new error outranks a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (err_event) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign err            = 1'b0;
   assign unused_err_clr = err_clr;
`endif

   // Stage chain: stage 0 takes accepted input, every later stage takes the
   // delayed pair of its predecessor.
   for (genvar k = 0; k < NST; k++) begin : g_stage
      logic src_valid;
      logic src_first;

      if (k == 0) begin : g_head
         assign src_valid = acc_valid;
         assign src_first = acc_first;
      end else begin : g_tail
         assign src_valid = act_vec[k-1];
         assign src_first = first_vec[k-1];
      end

      fft_stage_cnt #(
         .CBW  (CBW),
         .SLAT (SLAT)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (err_event),
         .in_valid  (src_valid),
         .in_first  (src_first),
         .out_valid (act_vec[k]),
         .out_first (first_vec[k]),
         .cnt       (cnt_arr[k])
      );

      assign stage_cnt[k*CBW +: CBW] = cnt_arr[k];
   end

   logic unused_tail_first;
   assign unused_tail_first = first_vec[NST-1];

   assign stage_act = act_vec;
   assign out_valid = act_vec[NST-1];
   assign out_first = act_vec[NST-1] && (cnt_arr[NST-1] == '0);
   assign out_last  = act_vec[NST-1] && (cnt_arr[NST-1] == {CBW{1'b1}});

endmodule

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: self-checking bench for fft_stage_seq with a directed
// single-frame vector table, hand-written corner sequences and randomized
// framed traffic checked against a cycle-history reference model.
module tb_fft_stage_seq;

   localparam int CBW  = 3;
   localparam int NST  = 3;
   localparam int SLAT = 2;
   localparam int N    = 1 << CBW;
   localparam int D    = NST * SLAT;
   localparam int MAXC = 2048;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_first = 1'b0;
   logic               err_clr = 1'b0;
   logic [NST*CBW-1:0] stage_cnt;
   logic [NST-1:0]     stage_act;
   logic               out_valid;
   logic               out_first;
   logic               out_last;
   logic               busy;
   logic               err;

   fft_stage_seq #(.CBW(CBW), .NST(NST), .SLAT(SLAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .stage_cnt (stage_cnt),
      .stage_act (stage_act),
      .out_valid (out_valid),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: history of accepted samples (with frame index) per cycle,
   // plus the sender-facing framing state expressed as plain integers.
   int  cyc = 0;
   bit  hv   [MAXC];
   int  hidx [MAXC];
   int  held [NST];
   bit  e_act [NST];
   int  e_cnt [NST];
   int  m_state = 0;
   int  m_pos   = 0;
   int  m_drain = 0;
   bit  m_err   = 1'b0;

   int  ov_count  = 0;
   int  of_count  = 0;
   int  ol_count  = 0;
   int  busy_low  = 0;

   typedef struct {
      bit v;
      bit f;
      bit e_act0;
      int e_cnt0;
      int e_cnt2;
      bit e_ov;
      bit e_of;
      bit e_ol;
      bit e_busy;
   } vec_t;

   vec_t vecs [18];

   // Watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog time=%0t limit=2000000", $time);
      $fatal(1);
   end

   task automatic check_val(input string name, input logic [31:0] got, input int want);
      total++;
      if (got !== 32'(want)) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pos   = 0;
      m_drain = 0;
      m_err   = 1'b0;
      for (int k = 0; k < NST; k++) held[k] = 0;
      for (int i = 0; i <= cyc && i < MAXC; i++) hv[i] = 1'b0;
   endtask

   // Stage k shows the sample accepted (k+1)*SLAT cycles earlier; otherwise it holds.
   task automatic model_expect();
      for (int k = 0; k < NST; k++) begin
         int src;
         src = cyc - (k + 1) * SLAT;
         if (src >= 0 && hv[src]) begin
            e_act[k] = 1'b1;
            e_cnt[k] = hidx[src];
            held[k]  = hidx[src];
         end else begin
            e_act[k] = 1'b0;
            e_cnt[k] = held[k];
         end
      end
   endtask

   task automatic model_update(input bit v, input bit f, input bit clr);
      bit acc;
      int idx;
      bit ev;
      bit ferr;
      acc  = 1'b0;
      idx  = 0;
      ev   = 1'b0;
      ferr = 1'b0;
      case (m_state)
         0: begin
            if (v && f) begin
               acc = 1'b1; idx = 0; m_pos = 1; m_state = 1;
            end
         end
         1: begin
`ifdef FFT_SEQ_ERR_EN
            ferr = (m_pos != 0 && (!v || f)) || (m_pos == 0 && v && !f);
`endif
            if (ferr) begin
               ev = 1'b1; m_state = 0; m_pos = 0;
            end else if (!v) begin
               m_state = 2; m_drain = D;
            end else begin
               acc = 1'b1; idx = m_pos; m_pos = (m_pos + 1) % N;
            end
         end
         default: begin
            if (v && f) begin
               acc = 1'b1; idx = 0; m_pos = 1; m_state = 1;
            end else begin
               m_drain--;
               if (m_drain == 0) m_state = 0;
            end
         end
      endcase
      hv[cyc]   = acc;
      hidx[cyc] = idx;
      if (ev) begin
         for (int i = (cyc > D ? cyc - D : 0); i <= cyc; i++) hv[i] = 1'b0;
         for (int k = 0; k < NST; k++) held[k] = 0;
      end
`ifdef FFT_SEQ_ERR_EN
      if (ev) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
`endif
   endtask

   task automatic checkOutput();
      bit exp_ov;
      for (int k = 0; k < NST; k++) begin
         check_val($sformatf("stage_act[%0d]", k), 32'(stage_act[k]), int'(e_act[k]));
         check_val($sformatf("stage_cnt[%0d]", k), 32'(stage_cnt[k*CBW +: CBW]), e_cnt[k]);
      end
      exp_ov = e_act[NST-1];
      check_val("out_valid", 32'(out_valid), int'(exp_ov));
      check_val("out_first", 32'(out_first), int'(exp_ov && e_cnt[NST-1] == 0));
      check_val("out_last", 32'(out_last), int'(exp_ov && e_cnt[NST-1] == N - 1));
      check_val("busy", 32'(busy), int'(m_state != 0));
      check_val("err", 32'(err), int'(m_err));
   endtask

   // One clock cycle: drive, check current outputs against the model, advance.
   task automatic applyStimulus(input bit v, input bit f, input bit clr);
      if (cyc >= MAXC) begin
         $display("[TB] FAIL history_overflow cycle=%0d limit=%0d", cyc, MAXC);
         $fatal(1);
      end
      in_valid = v;
      in_first = f;
      err_clr  = clr;
      model_expect();
      checkOutput();
      ov_count += int'(out_valid);
      of_count += int'(out_first);
      ol_count += int'(out_last);
      busy_low += int'(!busy);
      model_update(v, f, clr);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_counts();
      ov_count = 0; of_count = 0; ol_count = 0; busy_low = 0;
   endtask

   initial begin
      for (int t = 0; t < 18; t++) begin
         vecs[t].v      = (t < 8);
         vecs[t].f      = (t == 0);
         vecs[t].e_act0 = (t >= 2 && t <= 9);
         vecs[t].e_cnt0 = (t < 2) ? 0 : ((t <= 9) ? t - 2 : 7);
         vecs[t].e_cnt2 = (t < 6) ? 0 : ((t <= 13) ? t - 6 : 7);
         vecs[t].e_ov   = (t >= 6 && t <= 13);
         vecs[t].e_of   = (t == 6);
         vecs[t].e_ol   = (t == 13);
         vecs[t].e_busy = (t >= 1 && t <= 14);
      end

      // Reset state.
      #1;
      model_reset();
      model_expect();
      checkOutput();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;

      // Single frame against the directed table.
      for (int t = 0; t < 18; t++) begin
         check_val("tbl_act0", 32'(stage_act[0]), int'(vecs[t].e_act0));
         check_val("tbl_cnt0", 32'(stage_cnt[0 +: CBW]), vecs[t].e_cnt0);
         check_val("tbl_cnt2", 32'(stage_cnt[2*CBW +: CBW]), vecs[t].e_cnt2);
         check_val("tbl_out_valid", 32'(out_valid), int'(vecs[t].e_ov));
         check_val("tbl_out_first", 32'(out_first), int'(vecs[t].e_of));
         check_val("tbl_out_last", 32'(out_last), int'(vecs[t].e_ol));
         check_val("tbl_busy", 32'(busy), int'(vecs[t].e_busy));
         applyStimulus(vecs[t].v, vecs[t].f, 1'b0);
      end

      // Three back-to-back frames.
      clear_counts();
      for (int i = 0; i < 24; i++) applyStimulus(1'b1, (i % N) == 0, 1'b0);
      idle_cycles(12);
      check_val("b2b_out_valid_count", 32'(ov_count), 24);
      check_val("b2b_out_first_count", 32'(of_count), 3);
      check_val("b2b_out_last_count", 32'(ol_count), 3);

      // Valid dropped at sample index 4, then clear the error.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef FFT_SEQ_ERR_EN
      check_val("drop_err", 32'(err), 1);
      check_val("drop_act", 32'(stage_act), 0);
      check_val("drop_busy", 32'(busy), 0);
`endif
      clear_counts();
      idle_cycles(3);
      applyStimulus(1'b0, 1'b0, 1'b1);
      check_val("drop_err_cleared", 32'(err), 0);
      idle_cycles(8);

      // Stray first at sample index 3.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 0) || (i == 3), 1'b0);
      idle_cycles(12);
      applyStimulus(1'b0, 1'b0, 1'b1);
      idle_cycles(2);

      // New frame accepted two cycles into the drain.
      clear_counts();
      applyStimulus(1'b1, 1'b1, 1'b0);
      busy_low = 0;
      for (int i = 1; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      idle_cycles(3);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1'b0);
      check_val("drain_busy_low", 32'(busy_low), 0);
      idle_cycles(12);
      check_val("drain_out_first_count", 32'(of_count), 2);
      check_val("drain_out_last_count", 32'(ol_count), 2);

      // Asynchronous reset at sample 5.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, 1'b0);
      in_valid = 1'b1;
      in_first = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_stage_act", 32'(stage_act), 0);
      check_val("rst_stage_cnt", 32'(stage_cnt), 0);
      check_val("rst_out_valid", 32'(out_valid), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_err", 32'(err), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      cyc++;
      for (int i = 0; i < 10; i++) begin
         check_val("rst_no_output", 32'(out_valid), 0);
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1'b0);
      idle_cycles(10);

      // Randomized framed traffic with occasional framing faults.
      begin
         int pos;
         pos = -1;
         for (int i = 0; i < 800; i++) begin
            bit v;
            bit f;
            bit c;
            int r;
            v = 1'b0;
            f = 1'b0;
            c = ($urandom_range(0, 9) == 0);
            if (pos >= 0) begin
               v = 1'b1;
               f = (pos == 0);
               r = int'($urandom_range(0, 99));
               if (r < 3) v = 1'b0;
               else if (r < 5) f = !f;
               pos = (pos + 1) % N;
               if (pos == 0 && $urandom_range(0, 3) == 0) pos = -1;
               if (!v) pos = -1;
            end else begin
               if ($urandom_range(0, 5) == 0) begin
                  v = 1'b1; f = 1'b1; pos = 1;
               end else if ($urandom_range(0, 7) == 0) begin
                  v = 1'b1; f = 1'b0;
               end
            end
            applyStimulus(v, f, c);
         end
      end
      idle_cycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
